// File: rtl/pfpu32_addsub_rnd.sv
// rtl/pfpu32_addsub_rnd.sv - normalize/round/pack back end of the pfpu32 add/sub pipe
// Stage 1 aligns the 28-bit sum, stage 2 rounds to binary32 and resolves specials.
module pfpu32_addsub_rnd (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        adv_i,
  input  logic [1:0]  rmode_i,
  input  logic        add_rdy_i,
  input  logic        add_sign_i,
  input  logic        add_sub_0_i,
  input  logic [4:0]  add_shl_i,
  input  logic [9:0]  add_exp10shl_i,
  input  logic [9:0]  add_exp10sh0_i,
  input  logic [27:0] add_fract28_i,
  input  logic        add_inv_i,
  input  logic        add_inf_i,
  input  logic        add_snan_i,
  input  logic        add_qnan_i,
  input  logic        add_anan_sign_i,
  output logic        rnd_rdy_o,
  output logic [31:0] rnd_result_o,
  output logic        rnd_inv_o,
  output logic        rnd_inf_o,
  output logic        rnd_ovf_o,
  output logic        rnd_unf_o,
  output logic        rnd_ine_o,
  output logic        rnd_zero_o
);

  localparam logic [1:0] RM_NEAREST = 2'd0;
  localparam logic [1:0] RM_ZERO    = 2'd1;
  localparam logic [1:0] RM_UP      = 2'd2;
  localparam logic [1:0] RM_DOWN    = 2'd3;

  logic [27:0] al_d;
  logic [9:0]  e_d;

  always_comb begin
    al_d = add_fract28_i;
    e_d  = add_exp10sh0_i;
    if (add_fract28_i[27]) begin
      // Carry out: shift right once, folding the dropped bit into sticky.
      al_d = {1'b0, add_fract28_i[27:2], add_fract28_i[1] | add_fract28_i[0]};
      e_d  = add_exp10sh0_i + 10'd1;
    end else if (add_shl_i != 5'd0) begin
      al_d = add_fract28_i << add_shl_i;
      e_d  = add_exp10shl_i;
    end
  end

  logic        s1_rdy;
  logic [27:0] s1_al;
  logic [9:0]  s1_e;
  logic        s1_sign;
  logic        s1_sub_0;
  logic        s1_inv;
  logic        s1_inf;
  logic        s1_nan;
  logic        s1_anan_sign;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_rdy       <= 1'b0;
      s1_al        <= 28'd0;
      s1_e         <= 10'd0;
      s1_sign      <= 1'b0;
      s1_sub_0     <= 1'b0;
      s1_inv       <= 1'b0;
      s1_inf       <= 1'b0;
      s1_nan       <= 1'b0;
      s1_anan_sign <= 1'b0;
    end else begin
      if (flush_i)
        s1_rdy <= 1'b0;
      else if (adv_i)
        s1_rdy <= add_rdy_i;
      if (adv_i) begin
        s1_al        <= al_d;
        s1_e         <= e_d;
        s1_sign      <= add_sign_i;
        s1_sub_0     <= add_sub_0_i;
        s1_inv       <= add_inv_i;
        s1_inf       <= add_inf_i;
        s1_nan       <= add_snan_i | add_qnan_i;
        s1_anan_sign <= add_anan_sign_i;
      end
    end
  end

  logic        lsb, rbit, sbit, inexact, up, ovf, to_inf;
  logic [24:0] m25;
  logic [23:0] mant;
  logic [9:0]  e2;
  logic [7:0]  exp_field;
  logic [31:0] res_d;
  logic        inv_d, inf_d, ovf_d, unf_d, ine_d, zero_d;

  always_comb begin
    lsb     = s1_al[3];
    rbit    = s1_al[2];
    sbit    = |s1_al[1:0];
    inexact = rbit | sbit;
    case (rmode_i)
      RM_NEAREST: up = rbit & (sbit | lsb);
      RM_ZERO:    up = 1'b0;
      RM_UP:      up = ~s1_sign & inexact;
      RM_DOWN:    up = s1_sign & inexact;
      default:    up = 1'b0;
    endcase
    m25 = {1'b0, s1_al[26:3]} + {24'd0, up};
    if (m25[24]) begin
      mant = m25[24:1];
      e2   = s1_e + 10'd1;
    end else begin
      mant = m25[23:0];
      e2   = s1_e;
    end
    exp_field = mant[23] ? e2[7:0] : 8'd0;
    ovf       = (e2 >= 10'd255);
    to_inf    = (rmode_i == RM_NEAREST) || ((rmode_i == RM_UP) && !s1_sign) ||
                ((rmode_i == RM_DOWN) && s1_sign);

    res_d  = {s1_sign, exp_field, mant[22:0]};
    inv_d  = s1_inv;
    inf_d  = 1'b0;
    ovf_d  = 1'b0;
    unf_d  = inexact & ~mant[23];
    ine_d  = inexact;
    zero_d = (mant == 24'd0);

    if (ovf) begin
      res_d  = to_inf ? {s1_sign, 8'hFF, 23'd0} : {s1_sign, 31'h7F7FFFFF};
      inf_d  = to_inf;
      ovf_d  = 1'b1;
      ine_d  = 1'b1;
      zero_d = 1'b0;
    end

    if (s1_nan || s1_inv || s1_inf || s1_sub_0) begin
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
      ine_d  = 1'b0;
      inf_d  = 1'b0;
      zero_d = 1'b0;
      if (s1_nan) begin
        res_d = {s1_anan_sign, 8'hFF, 1'b1, 22'd0};
      end else if (s1_inv) begin
        res_d = 32'h7FC00000;
      end else if (s1_inf) begin
        res_d = {s1_sign, 8'hFF, 23'd0};
        inf_d = 1'b1;
      end else begin
        res_d  = {(rmode_i == RM_DOWN), 31'd0};
        zero_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rnd_rdy_o    <= 1'b0;
      rnd_result_o <= 32'd0;
      rnd_inv_o    <= 1'b0;
      rnd_inf_o    <= 1'b0;
      rnd_ovf_o    <= 1'b0;
      rnd_unf_o    <= 1'b0;
      rnd_ine_o    <= 1'b0;
      rnd_zero_o   <= 1'b0;
    end else begin
      if (flush_i)
        rnd_rdy_o <= 1'b0;
      else if (adv_i)
        rnd_rdy_o <= s1_rdy;
      if (adv_i) begin
        rnd_result_o <= res_d;
        rnd_inv_o    <= inv_d;
        rnd_inf_o    <= inf_d;
        rnd_ovf_o    <= ovf_d;
        rnd_unf_o    <= unf_d;
        rnd_ine_o    <= ine_d;
        rnd_zero_o   <= zero_d;
      end
    end
  end

endmodule
